// File: rtl/box_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : box_motion_ctrl
//  Purpose  : Per-frame motion controller for a bouncing box overlay. On each
//             accepted frame_start the box advances by (speed+1) pixels on
//             both axes, clamping and reversing at the visible-area edges.
//             The new position is computed into shadow registers and only
//             published in the COMMIT cycle, so consumers never observe a
//             half-updated position.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1   single clock, all state on rising edge
//    rst_n       in   1   asynchronous active-low reset
//    ena         in   1   design selected; low behaves as pause
//    frame_start in   1   one-cycle pulse at start of vertical blank
//    pause       in   1   freezes motion while high
//    speed       in   3   step = speed+1 pixels per frame
//    box_x       out 10   committed box left edge
//    box_y       out 10   committed box top edge
//    dir_x       out  1   1 = moving right
//    dir_y       out  1   1 = moving down
//    color_idx   out  3   colour index, advances once per axis hit
//    bounce      out  1   one-cycle pulse when any edge is hit
//    corner      out  1   one-cycle pulse when both axes hit together
//    busy        out  1   high while an update is in flight
//    frame_skip  out  1   one-cycle pulse when a frame_start is dropped
// ============================================================================
module box_motion_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int BOX_SIZE = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       frame_start,
   input  logic       pause,
   input  logic [2:0] speed,
   output logic [9:0] box_x,
   output logic [9:0] box_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic [2:0] color_idx,
   output logic       bounce,
   output logic       corner,
   output logic       busy,
   output logic       frame_skip
);

   // Furthest legal top-left coordinate on each axis.
   localparam logic [9:0] MAX_X = 10'(H_ACTIVE - BOX_SIZE);
   localparam logic [9:0] MAX_Y = 10'(V_ACTIVE - BOX_SIZE);
   // Box starts centred.
   localparam logic [9:0] RST_X = 10'((H_ACTIVE - BOX_SIZE) / 2);
   localparam logic [9:0] RST_Y = 10'((V_ACTIVE - BOX_SIZE) / 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MOVE_X = 2'd1,
      ST_MOVE_Y = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] step_q, step_d;

   // Shadow registers holding the next position while the update is in flight.
   logic [9:0] nx_q, nx_d;
   logic [9:0] ny_q, ny_d;
   logic       ndir_x_q, ndir_x_d;
   logic       ndir_y_q, ndir_y_d;
   logic       hit_x_q, hit_x_d;
   logic       hit_y_q, hit_y_d;

   // Committed, externally visible state.
   logic [9:0] box_x_q, box_x_d;
   logic [9:0] box_y_q, box_y_d;
   logic       dir_x_q, dir_x_d;
   logic       dir_y_q, dir_y_d;
   logic [2:0] color_q, color_d;
   logic       bounce_q, bounce_d;
   logic       corner_q, corner_d;
   logic       busy_q, busy_d;
   logic       frame_skip_q, frame_skip_d;

   // Result packing: {hit, new_dir, new_pos[9:0]}
   logic [11:0] x_res;
   logic [11:0] y_res;

   // One axis of motion. The edge tests run in 11 bits so that pos+step can
   // never wrap, and the left test uses pos <= step so subtraction cannot
   // underflow. When no clamp occurs the 10-bit result is always below the
   // limit, so the narrower add/subtract is exact.
   function automatic logic [11:0] axis_next(
      input logic [9:0] pos,
      input logic       dir,
      input logic [3:0] step,
      input logic [9:0] lim
   );
      logic [10:0] pos_w;
      logic [10:0] step_w;
      logic [10:0] sum_w;
      logic [11:0] res;
      pos_w  = {1'b0, pos};
      step_w = {7'd0, step};
      sum_w  = pos_w + step_w;
      res    = {1'b0, dir, pos};
      if (dir) begin
         if (sum_w >= {1'b0, lim}) begin
            res = {1'b1, 1'b0, lim};
         end else begin
            res = {1'b0, 1'b1, pos + {6'd0, step}};
         end
      end else begin
         if (pos_w <= step_w) begin
            res = {1'b1, 1'b1, 10'd0};
         end else begin
            res = {1'b0, 1'b0, pos - {6'd0, step}};
         end
      end
      return res;
   endfunction

   assign x_res = axis_next(box_x_q, dir_x_q, step_q, MAX_X);
   assign y_res = axis_next(box_y_q, dir_y_q, step_q, MAX_Y);

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      nx_d     = nx_q;
      ny_d     = ny_q;
      ndir_x_d = ndir_x_q;
      ndir_y_d = ndir_y_q;
      hit_x_d  = hit_x_q;
      hit_y_d  = hit_y_q;
      box_x_d  = box_x_q;
      box_y_d  = box_y_q;
      dir_x_d  = dir_x_q;
      dir_y_d  = dir_y_q;
      color_d  = color_q;
      bounce_d = 1'b0;
      corner_d = 1'b0;

      // Any frame_start arriving mid-update is discarded and flagged.
      frame_skip_d = frame_start && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (frame_start && ena && !pause) begin
               state_d = ST_MOVE_X;
               step_d  = {1'b0, speed} + 4'd1;
            end
         end
         ST_MOVE_X: begin
            hit_x_d  = x_res[11];
            ndir_x_d = x_res[10];
            nx_d     = x_res[9:0];
            state_d  = ST_MOVE_Y;
         end
         ST_MOVE_Y: begin
            hit_y_d  = y_res[11];
            ndir_y_d = y_res[10];
            ny_d     = y_res[9:0];
            state_d  = ST_COMMIT;
         end
         ST_COMMIT: begin
            box_x_d  = nx_q;
            box_y_d  = ny_q;
            dir_x_d  = ndir_x_q;
            dir_y_d  = ndir_y_q;
            // One colour advance per axis that hit; a corner advances by two.
            color_d  = color_q + {2'b00, hit_x_q} + {2'b00, hit_y_q};
            bounce_d = hit_x_q | hit_y_q;
            corner_d = hit_x_q & hit_y_q;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // busy is registered alongside the state so it tracks it exactly.
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         step_q       <= 4'd1;
         nx_q         <= 10'd0;
         ny_q         <= 10'd0;
         ndir_x_q     <= 1'b0;
         ndir_y_q     <= 1'b0;
         hit_x_q      <= 1'b0;
         hit_y_q      <= 1'b0;
         box_x_q      <= RST_X;
         box_y_q      <= RST_Y;
         dir_x_q      <= 1'b1;
         dir_y_q      <= 1'b1;
         color_q      <= 3'd0;
         bounce_q     <= 1'b0;
         corner_q     <= 1'b0;
         busy_q       <= 1'b0;
         frame_skip_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         nx_q         <= nx_d;
         ny_q         <= ny_d;
         ndir_x_q     <= ndir_x_d;
         ndir_y_q     <= ndir_y_d;
         hit_x_q      <= hit_x_d;
         hit_y_q      <= hit_y_d;
         box_x_q      <= box_x_d;
         box_y_q      <= box_y_d;
         dir_x_q      <= dir_x_d;
         dir_y_q      <= dir_y_d;
         color_q      <= color_d;
         bounce_q     <= bounce_d;
         corner_q     <= corner_d;
         busy_q       <= busy_d;
         frame_skip_q <= frame_skip_d;
      end
   end

   assign box_x      = box_x_q;
   assign box_y      = box_y_q;
   assign dir_x      = dir_x_q;
   assign dir_y      = dir_y_q;
   assign color_idx  = color_q;
   assign bounce     = bounce_q;
   assign corner     = corner_q;
   assign busy       = busy_q;
   assign frame_skip = frame_skip_q;

endmodule
`default_nettype wire
